mim_cap_charge_meter: RTL and testbench

- Digital readout sequencer for on-chip MIM capacitor characterisation; it is the measuring end of the constant-current charge test.
- Discharges the cap, enables a constant-current source, and counts clock cycles until an external comparator reports that the cap voltage crossed the reference.
- Repeats the measurement 2^AVG_LOG2 times and accumulates the counts.
- Sits between the test-control register block and the analog switch/comparator cell of the cap test structure.

---
 rtl/mim_cap_charge_meter.sv | 226 ++++++++++++++++++++++
 tb/tb_mim_cap_charge_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mim_cap_charge_meter.sv
// Measuring sequencer for the MIM capacitor constant-current charge test.
// Each run performs 2^AVG_LOG2 discharge/settle/charge measurements, counts
// the clock cycles until the synchronised comparator trips, and accumulates
// the counts into result_o. Stuck comparators and saturated counts are flagged.
module mim_cap_charge_meter #(
    parameter int CNT_W         = 16,
    parameter int AVG_LOG2      = 2,
    parameter int DIS_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      cmp_i,
    output logic                      dis_o,
    output logic                      chg_en_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      valid_o,
    output logic [CNT_W+AVG_LOG2-1:0] result_o,
    output logic                      err_timeout_o,
    output logic                      err_stuck_o
);

    localparam int ACC_W   = CNT_W + AVG_LOG2;
    localparam int TMR_MAX = (DIS_CYCLES > SETTLE_CYCLES) ? DIS_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [TMR_W-1:0] DIS_LAST    = TMR_W'(DIS_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
    // Counter value one below saturation: the increment from here times out.
    localparam logic [CNT_W-1:0] CNT_LAST    = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCHARGE,
        S_SETTLE,
        S_CHARGE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               dis_q, dis_d;
    logic               chg_q, chg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               err_to_q, err_to_d;
    logic               err_st_q, err_st_d;
    logic               cmp_meta_q, cmp_s_q;
    logic [ACC_W-1:0]   acc_sum;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= cmp_i;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    // State and registered-output flops; reset leaves the cap shorted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            dis_q    <= 1'b1;
            chg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            err_to_q <= 1'b0;
            err_st_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            dis_q    <= dis_d;
            chg_q    <= chg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            err_to_q <= err_to_d;
            err_st_q <= err_st_d;
        end
    end

    assign acc_sum = acc_q + ACC_W'(cnt_q);

    // Next-state and next-output logic; outputs are computed on the transition
    // so they are valid in the first cycle of the new state.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        dis_d    = dis_q;
        chg_d    = chg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        result_d = result_q;
        err_to_d = err_to_q;
        err_st_d = err_st_q;

        case (state_q)
            S_IDLE: begin
                dis_d = 1'b1;
                chg_d = 1'b0;
                if (start_i) begin
                    state_d  = S_DISCHARGE;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    result_d = '0;
                    err_to_d = 1'b0;
                    err_st_d = 1'b0;
                    acc_d    = '0;
                    idx_d    = '0;
                    tmr_d    = '0;
                end
            end

            S_DISCHARGE: begin
                dis_d = 1'b1;
                chg_d = 1'b0;
                if (tmr_q == DIS_LAST) begin
                    tmr_d   = '0;
                    dis_d   = 1'b0;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d = '0;
                    if (cmp_s_q) begin
                        // Comparator already high with no charge applied.
                        err_st_d = 1'b1;
                        dis_d    = 1'b1;
                        done_d   = 1'b1;
                        valid_d  = 1'b0;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        chg_d   = 1'b1;
                        state_d = S_CHARGE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_CHARGE: begin
                if (cmp_s_q) begin
                    acc_d = acc_sum;
                    chg_d = 1'b0;
                    dis_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d   = 1'b1;
                        valid_d  = 1'b1;
                        result_d = acc_sum;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tmr_d   = '0;
                        state_d = S_DISCHARGE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Saturated without a trip: abort, count is discarded.
                    cnt_d    = CNT_SAT;
                    err_to_d = 1'b1;
                    chg_d    = 1'b0;
                    dis_d    = 1'b1;
                    done_d   = 1'b1;
                    valid_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                dis_d   = 1'b1;
                chg_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dis_o         = dis_q;
    assign chg_en_o      = chg_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign valid_o       = valid_q;
    assign result_o      = result_q;
    assign err_timeout_o = err_to_q;
    assign err_stuck_o   = err_st_q;

endmodule

// File: tb/tb_mim_cap_charge_meter.sv
// Scoreboard bench: each run pushes its expected outcome (derived from the
// trip edges as sum of N+1) and a done_o monitor pops and compares.
module tb_mim_cap_charge_meter;

    localparam int CNT_W = 16;
    localparam int AVG   = 2;
    localparam int DIS   = 64;
    localparam int SET   = 8;
    localparam int RW    = CNT_W + AVG;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, cmp;
    logic          dis, chg, busy, done, valid, st, to;
    logic [RW-1:0] result;

    logic          start8, cmp8;
    logic          dis8, chg8, busy8, done8, valid8, st8, to8;
    logic [9:0]    result8;

    always #5 clk = ~clk;

    mim_cap_charge_meter #(.CNT_W(CNT_W), .AVG_LOG2(AVG), .DIS_CYCLES(DIS), .SETTLE_CYCLES(SET)) dut (
        .clk(clk), .rst(rst), .start_i(start), .cmp_i(cmp),
        .dis_o(dis), .chg_en_o(chg), .busy_o(busy), .done_o(done), .valid_o(valid),
        .result_o(result), .err_timeout_o(to), .err_stuck_o(st)
    );

    mim_cap_charge_meter #(.CNT_W(8), .AVG_LOG2(2), .DIS_CYCLES(4), .SETTLE_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .cmp_i(cmp8),
        .dis_o(dis8), .chg_en_o(chg8), .busy_o(busy8), .done_o(done8), .valid_o(valid8),
        .result_o(result8), .err_timeout_o(to8), .err_stuck_o(st8)
    );

    typedef struct {
        longint res;
        bit     v;
        bit     st;
        bit     to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   done_cnt = 0;
    int   trips[4];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done_o pulse consumes one expected outcome.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("valid", valid, e.v);
                chk("err_stuck", st, e.st);
                chk("err_timeout", to, e.to);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One full run with trip edges from trips[]; optionally pokes start_i in CHARGE and DONE.
    task automatic run_meas(input bit poke);
        exp_t e;
        longint sum = 0;
        int d0, gap, hi, guard;
        for (int i = 0; i < 4; i++) sum += trips[i] + 1;
        e.res = sum; e.v = 1'b1; e.st = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        d0 = done_cnt;
        do_start();
        chk("accept_busy", busy, 1);
        chk("accept_clears", {valid, st, to}, 0);
        for (int i = 0; i < 4; i++) begin
            gap = 0; guard = 0;
            while (!chg && guard < 500) begin
                if (!dis) gap++;
                tick();
                guard++;
            end
            chk("gap_before_charge", gap, SET);
            if (poke && i == 1) start = 1'b1;
            for (int k = 1; k < trips[i]; k++) begin
                tick();
                start = 1'b0;
            end
            start = 1'b0;
            cmp = 1'b1;
            guard = 0;
            while (!dis && guard < 2000) begin
                tick();
                guard++;
            end
            cmp = 1'b0;
            if (i < 3) begin
                hi = 0; guard = 0;
                while (dis && guard < 500) begin
                    hi++;
                    tick();
                    guard++;
                end
                chk("dis_width", hi, DIS);
            end else if (poke) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        repeat (20) tick();
        chk("idle_state", {busy, dis, chg}, 3'b010);
        chk("one_done", done_cnt - d0, 1);
    endtask

    initial begin
        int guard, n, chc;
        bit sawchg;
        exp_t e;
        rst = 1'b1; start = 1'b0; cmp = 1'b0; start8 = 1'b0; cmp8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", {dis, chg, busy, done, valid, st, to}, 7'b1000000);
        chk("reset_result", result, 0);
        chk("reset_outputs8", {dis8, chg8, busy8, done8, valid8, st8, to8}, 7'b1000000);

        // Reset asserted mid-CHARGE aborts at once and leaves no done pulse.
        do_start();
        guard = 0;
        while (!chg && guard < 500) begin tick(); guard++; end
        repeat (5) tick();
        #2 rst = 1'b1;
        #1 chk("async_reset_abort", {dis, chg, busy}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        n = done_cnt;
        repeat (200) tick();
        chk("no_done_after_reset", done_cnt - n, 0);
        chk("idle_after_reset", busy, 0);

        // Nominal run: trip before edge 99 -> 100 per measurement.
        for (int k = 0; k < 4; k++) trips[k] = 99;
        run_meas(1'b0);
        chk("nominal_valid_held", {valid, result}, {1'b1, 18'd400});

        // Varying trip edges.
        trips[0] = 10; trips[1] = 20; trips[2] = 30; trips[3] = 40;
        run_meas(1'b0);

        // Stuck comparator.
        cmp = 1'b1;
        repeat (4) tick();
        e.res = 0; e.v = 1'b0; e.st = 1'b1; e.to = 1'b0;
        sb.push_back(e);
        do_start();
        chk("stuck_accept_clears_valid", valid, 0);
        n = 0; sawchg = 1'b0; guard = 0;
        while (!done && guard < 1000) begin
            if (chg) sawchg = 1'b1;
            tick();
            n++;
            guard++;
        end
        chk("stuck_latency", n, DIS + SET);
        chk("stuck_no_charge", sawchg, 0);
        cmp = 1'b0;
        repeat (10) tick();
        chk("stuck_flags_hold", {st, valid, busy}, 3'b100);

        // Start while busy (CHARGE and DONE); accept clears the stuck flag.
        trips[0] = 5; trips[1] = 17; trips[2] = 1; trips[3] = 64;
        run_meas(1'b1);

        // Randomised runs.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) trips[k] = int'($urandom_range(150, 1));
            run_meas(1'($urandom_range(1, 0)));
        end

        // Timeout on the 8-bit instance.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chc = 0; guard = 0;
        while (!done8 && guard < 2000) begin
            if (chg8) chc++;
            tick();
            guard++;
        end
        chk("timeout_charge_cycles", chc, 255);
        chk("timeout_flags", {to8, st8, valid8, chg8, done8}, 5'b10001);
        chk("timeout_result", result8, 0);
        repeat (3) tick();
        chk("timeout_idle", busy8, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
